// File: rtl/calendar_pkg.sv
// Shared definitions for the calendar counter.
//   field_t      : encoding of the field_sel input (day / month / year / none)
//   rpt_state_t  : states of the inc/dec auto-repeat machine
//   month_len()  : number of days in a month, given the leap flag of its year
package calendar_pkg;

    typedef enum logic [1:0] {
        FIELD_DAY   = 2'd0,
        FIELD_MONTH = 2'd1,
        FIELD_YEAR  = 2'd2,
        FIELD_NONE  = 2'd3
    } field_t;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_FIRST  = 2'd1,
        RPT_DELAY  = 2'd2,
        RPT_REPEAT = 2'd3
    } rpt_state_t;

    localparam logic [3:0] MONTH_JAN = 4'd1;
    localparam logic [3:0] MONTH_DEC = 4'd12;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap_yr);
        case (m)
            4'd2:                      month_len = leap_yr ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
            default:                   month_len = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/step_repeater.sv
// Converts the inc/dec button levels into single-cycle step pulses with
// keyboard-style auto-repeat.
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : set mode; steps are only generated while high
//   field_sel [1:0]   : edited field; any change cancels a running repeat
//   inc, dec          : button levels (both high = no step, repeat cancelled)
//   step_inc/step_dec : step pulses, valid in the same cycle as the press so
//                       the field updates on the following edge
// First step on the first cycle a button is seen, the next one RPT_DLY cycles
// later, then one every RPT_PER cycles until released.
module step_repeater
    import calendar_pkg::*;
#(
    parameter int RPT_DLY = 8,
    parameter int RPT_PER = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] field_sel,
    input  logic       inc,
    input  logic       dec,
    output logic       step_inc,
    output logic       step_dec
);

    localparam int CNT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    rpt_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;     // cycles elapsed since the last step
    logic             dir_reg;     // 1 = repeating inc, 0 = repeating dec
    logic [1:0]       field_sel_reg;

    logic press_inc;
    logic press_dec;
    logic held;
    logic abort;
    logic step_now;
    logic step_dir;

    assign press_inc = inc & ~dec;
    assign press_dec = dec & ~inc;
    // The repeat only continues while the same single button stays pressed.
    assign held      = dir_reg ? press_inc : press_dec;
    assign abort     = ~enable | ~held | (field_sel != field_sel_reg);

    always_comb begin
        step_now = 1'b0;
        case (state_reg)
            RPT_IDLE:   step_now = enable & (press_inc | press_dec);
            RPT_FIRST,
            RPT_DELAY:  step_now = ~abort & (cnt_reg == CNT_W'(RPT_DLY));
            RPT_REPEAT: step_now = ~abort & (cnt_reg == CNT_W'(RPT_PER));
            default:    step_now = 1'b0;
        endcase
    end

    assign step_dir = (state_reg == RPT_IDLE) ? press_inc : dir_reg;
    assign step_inc = step_now & step_dir;
    assign step_dec = step_now & ~step_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RPT_IDLE;
            cnt_reg       <= '0;
            dir_reg       <= 1'b0;
            field_sel_reg <= 2'd0;
        end else begin
            field_sel_reg <= field_sel;
            case (state_reg)
                RPT_IDLE: begin
                    if (step_now) begin
                        state_reg <= RPT_FIRST;
                        cnt_reg   <= CNT_W'(1);
                        dir_reg   <= press_inc;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end
                RPT_FIRST, RPT_DELAY: begin
                    if (abort) begin
                        state_reg <= RPT_IDLE;
                        cnt_reg   <= '0;
                    end else if (step_now) begin
                        state_reg <= RPT_REPEAT;
                        cnt_reg   <= CNT_W'(1);
                    end else begin
                        state_reg <= RPT_DELAY;
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (abort) begin
                        state_reg <= RPT_IDLE;
                        cnt_reg   <= '0;
                    end else if (step_now) begin
                        cnt_reg   <= CNT_W'(1);
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= RPT_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/calendar_counter.sv
// Day / month / year counter with Gregorian leap years and a set mode with
// auto-repeating inc/dec editing.
//   clk, rst_n           : clock, asynchronous active-low reset
//   tick_day             : one-cycle pulse advancing the date (run mode only)
//   ctrl_set             : set mode; tick_day is ignored while high
//   field_sel [1:0]      : field edited by inc/dec (day, month, year, none)
//   inc, dec             : edit button levels
//   day, month, year     : registered date
//   leap, month_end      : combinational status of the current date
//   carry_out            : pulse when a run-mode tick wraps YEAR_MAX-12-31
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_MIN = 2000,
    parameter int YEAR_MAX = 2999,
    parameter int YEAR_W   = 12,
    parameter int RPT_DLY  = 8,
    parameter int RPT_PER  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_day,
    input  logic              ctrl_set,
    input  logic [1:0]        field_sel,
    input  logic              inc,
    input  logic              dec,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              leap,
    output logic              month_end,
    output logic              carry_out
);

    localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        logic [31:0] yy;
        yy      = 32'(y);
        is_leap = ((yy % 32'd4) == 32'd0) &&
                  (((yy % 32'd100) != 32'd0) || ((yy % 32'd400) == 32'd0));
    endfunction

    logic [4:0]        day_reg,   day_next;
    logic [3:0]        month_reg, month_next;
    logic [YEAR_W-1:0] year_reg,  year_next;

    logic              step_inc;
    logic              step_dec;
    logic [4:0]        cur_len;
    logic              date_max;

    // Step-side candidate values, then the day clamped to the target month.
    logic [3:0]        step_month;
    logic [YEAR_W-1:0] step_year;
    logic [4:0]        month_len_new;
    logic [4:0]        year_len_new;

    step_repeater #(
        .RPT_DLY (RPT_DLY),
        .RPT_PER (RPT_PER)
    ) u_step_repeater (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (ctrl_set),
        .field_sel (field_sel),
        .inc       (inc),
        .dec       (dec),
        .step_inc  (step_inc),
        .step_dec  (step_dec)
    );

    assign leap      = is_leap(year_reg);
    assign cur_len   = month_len(month_reg, leap);
    assign month_end = (day_reg == cur_len);
    assign date_max  = (year_reg == Y_MAX) && (month_reg == MONTH_DEC) && (day_reg == 5'd31);
    assign carry_out = tick_day & ~ctrl_set & date_max;

    always_comb begin
        if (step_inc)
            step_month = (month_reg == MONTH_DEC) ? MONTH_JAN : month_reg + 4'd1;
        else
            step_month = (month_reg == MONTH_JAN) ? MONTH_DEC : month_reg - 4'd1;

        if (step_inc)
            step_year = (year_reg == Y_MAX) ? Y_MIN : year_reg + YEAR_W'(1);
        else
            step_year = (year_reg == Y_MIN) ? Y_MAX : year_reg - YEAR_W'(1);

        month_len_new = month_len(step_month, leap);
        year_len_new  = month_len(month_reg, is_leap(step_year));
    end

    always_comb begin
        day_next   = day_reg;
        month_next = month_reg;
        year_next  = year_reg;
        if (!ctrl_set) begin
            if (tick_day) begin
                if (!month_end) begin
                    day_next = day_reg + 5'd1;
                end else if (month_reg != MONTH_DEC) begin
                    day_next   = 5'd1;
                    month_next = month_reg + 4'd1;
                end else begin
                    day_next   = 5'd1;
                    month_next = MONTH_JAN;
                    year_next  = (year_reg == Y_MAX) ? Y_MIN : year_reg + YEAR_W'(1);
                end
            end
        end else if (step_inc || step_dec) begin
            case (field_t'(field_sel))
                FIELD_DAY: begin
                    if (step_inc)
                        day_next = month_end ? 5'd1 : day_reg + 5'd1;
                    else
                        day_next = (day_reg == 5'd1) ? cur_len : day_reg - 5'd1;
                end
                FIELD_MONTH: begin
                    month_next = step_month;
                    day_next   = (day_reg > month_len_new) ? month_len_new : day_reg;
                end
                FIELD_YEAR: begin
                    year_next = step_year;
                    day_next  = (day_reg > year_len_new) ? year_len_new : day_reg;
                end
                default: begin
                    day_next = day_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_reg   <= 5'd1;
            month_reg <= MONTH_JAN;
            year_reg  <= Y_MIN;
        end else begin
            day_reg   <= day_next;
            month_reg <= month_next;
            year_reg  <= year_next;
        end
    end

    assign day   = day_reg;
    assign month = month_reg;
    assign year  = year_reg;

endmodule

// File: doc/calendar_counter.md
CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 Parameter YEAR_MIN, default 2000, first year of the counted range and the reset year.
REQ-002 Parameter YEAR_MAX, default 2999, last year of the range; YEAR_MAX > YEAR_MIN.
REQ-003 Parameter YEAR_W, default 12, year field width; 2**YEAR_W > YEAR_MAX.
REQ-004 Parameter RPT_DLY, default 8, clk cycles a held inc/dec waits before auto-repeat starts.
REQ-005 Parameter RPT_PER, default 4, clk cycles between auto-repeat steps; RPT_PER >= 1.
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 tick_day  input  1  one-cycle day-advance pulse (carry from hour counter).
REQ-009 ctrl_set  input  1  set mode enable.
REQ-010 field_sel  input  2  edited field: 0 day, 1 month, 2 year, 3 none.
REQ-011 inc  input  1  level, increment the selected field.
REQ-012 dec  input  1  level, decrement the selected field.
REQ-013 day  output  5  day of month, 1..31, registered.
REQ-014 month  output  4  month, 1..12, registered.
REQ-015 year  output  YEAR_W  year, YEAR_MIN..YEAR_MAX, registered.
REQ-016 leap  output  1  current year is leap, combinational.
REQ-017 month_end  output  1  day equals last day of current month, combinational.
REQ-018 carry_out  output  1  rollover pulse, combinational: tick_day & !ctrl_set & date = YEAR_MAX-12-31.

Function
REQ-019 Leap rule SHALL be full Gregorian: divisible by 4, except by 100 unless by 400 (2000 leap, 2100 not).
REQ-020 Month length SHALL be 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29/28 for month 2 per leap.
REQ-021 Run mode (ctrl_set=0): tick_day SHALL advance the date by one day next cycle; month_end wraps day to 1 and month+1; Dec 31 wraps to Jan 1 and year+1.
REQ-022 At YEAR_MAX-12-31, tick_day SHALL load YEAR_MIN-01-01 and assert carry_out in the tick cycle.
REQ-023 Set mode: tick_day SHALL be ignored (no date change, carry_out low).
REQ-024 Step event SHALL be generated on the first cycle inc (or dec) is seen high while ctrl_set=1; if held, another step after RPT_DLY cycles, then every RPT_PER cycles until released.
REQ-025 inc and dec both high SHALL produce no step and reset the repeat FSM to IDLE.
REQ-026 Repeat FSM states: IDLE -> FIRST (step issued) -> DELAY (count RPT_DLY) -> REPEAT (step every RPT_PER); release, ctrl_set=0 or field_sel change -> IDLE next cycle.
REQ-027 Day step SHALL wrap within the current month (last->1 on inc, 1->last on dec) without changing month/year.
REQ-028 Month step SHALL wrap 12->1 / 1->12 without changing year, then clamp day to the new month length in the same update.
REQ-029 Year step SHALL wrap YEAR_MAX->YEAR_MIN / YEAR_MIN->YEAR_MAX, then clamp day (Feb 29 -> Feb 28 in non-leap target).
REQ-030 field_sel=3 SHALL ignore steps; carry_out SHALL never assert from set-mode wraps.
REQ-031 Step latency SHALL be one cycle: field updated on the clock edge after the step cycle.

Reset
REQ-032 Async reset SHALL set day=1, month=1, year=YEAR_MIN, repeat FSM IDLE, repeat counter 0.
REQ-033 Reset mid-repeat or mid-tick SHALL take effect immediately; first edge after deassertion applies no stale step.

Structure
REQ-034 Package calendar_pkg SHALL hold field_sel encodings, repeat FSM state type and month-length function.
REQ-035 Sub-module step_repeater (inc/dec level -> step_inc/step_dec pulses, RPT_DLY/RPT_PER) SHALL be instantiated once.

Verification
REQ-036 Reset, 366 tick_day pulses from 2000-01-01 -> 2001-01-01, passing 2000-02-29.
REQ-037 Date 2100-02-28, one tick -> 2100-03-01; leap=0.
REQ-038 Date 2999-12-31, tick -> 2000-01-01, carry_out high exactly in tick cycle.
REQ-039 Set mode, 2024-01-31, field month, inc one step -> 2024-02-29; year inc -> 2025-02-28.
REQ-040 Set mode, field day, inc held 8+4*3+1 cycles -> 5 steps total (day 1 -> 6); tick_day during it ignored.
REQ-041 inc and dec asserted together 20 cycles in set mode -> no field change; rst_n low mid-repeat -> 2000-01-01.
